// File: rtl/fp_mul_arbiter_pkg.sv
// Shared constants for the FP multiplier front-end: requester count, tag depth, flag width.
// Pure definitions; no logic, no latency, no backpressure.
package fp_mul_arbiter_pkg;

    localparam int FP_NUM_REQ   = 4;
    localparam int FP_TAG_DEPTH = 8;
    localparam int FP_FLAG_W    = 5;
    localparam int FP_WORD_W    = 32;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/fp_tag_fifo.sv
// Requester-id FIFO: zero-latency head, one-cycle push-to-visible.
// Push refused when full unless a pop lands in the same cycle.
module fp_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;
    // When full, the slot being popped this cycle is the one the push reuses.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin front-end sharing one FP multiplier; zero added latency, in-order responses.
// A stalled grant is locked until issue; tag FIFO full blocks issue; rsp_ready of the head gates the multiplier.
module fp_mul_arbiter
    import fp_mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = FP_NUM_REQ,
    parameter int TAG_DEPTH = FP_TAG_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*32-1:0]     req_op_a,
    input  logic [NUM_REQ*32-1:0]     req_op_b,
    input  logic [NUM_REQ-1:0]        req_mode_fp,
    output logic                      mul_start,
    input  logic                      mul_ready,
    output logic [FP_WORD_W-1:0]      mul_op_a,
    output logic [FP_WORD_W-1:0]      mul_op_b,
    output logic                      mul_mode_fp,
    input  logic                      mul_valid,
    output logic                      mul_ready_in,
    input  logic [FP_WORD_W-1:0]      mul_result,
    input  logic [FP_FLAG_W-1:0]      mul_flags,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [FP_WORD_W-1:0]      rsp_result,
    output logic [FP_FLAG_W-1:0]      rsp_flags,
    output logic                      busy,
    output logic                      err_orphan
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = $clog2(TAG_DEPTH) + 1;

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 lock_q, lock_d;
    logic [ID_W-1:0]      lock_id_q, lock_id_d;
    logic                 err_orphan_q, err_orphan_d;

    logic [FP_WORD_W-1:0] op_a_arr [NUM_REQ];
    logic [FP_WORD_W-1:0] op_b_arr [NUM_REQ];
    logic [ID_W-1:0]      rr_idx;
    logic [ID_W-1:0]      rr_grant;
    logic                 rr_found;
    logic                 lock_hold;
    logic [ID_W-1:0]      grant;
    logic                 any_req;
    logic                 slot_free;
    logic                 issue;
    logic                 pop;

    logic                 tag_full;
    logic                 tag_empty;
    logic [ID_W-1:0]      tag_head;
    logic [CW-1:0]        tag_count;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a_arr[i] = req_op_a[32*i +: 32];
            op_b_arr[i] = req_op_b[32*i +: 32];
        end
    end

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        rr_idx   = '0;
        rr_grant = rr_ptr_q;
        rr_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

    // A locked requester that withdrew its request falls back to normal arbitration.
    assign lock_hold = lock_q && req_valid[lock_id_q];
    assign grant     = lock_hold ? lock_id_q : rr_grant;
    assign any_req   = lock_hold || rr_found;

    assign mul_ready_in = rst_n && (tag_empty || rsp_ready[tag_head]);
    assign pop          = mul_valid && mul_ready_in && !tag_empty;
    assign slot_free    = (tag_count < CW'(TAG_DEPTH)) || pop;
    assign mul_start    = rst_n && any_req && slot_free;
    assign issue        = mul_start && mul_ready;

    assign mul_op_a    = op_a_arr[grant];
    assign mul_op_b    = op_b_arr[grant];
    assign mul_mode_fp = req_mode_fp[grant];

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (issue) begin
            req_ready[grant] = 1'b1;
        end
        if (rst_n && mul_valid && !tag_empty) begin
            rsp_valid[tag_head] = 1'b1;
        end
    end

    assign rsp_result = mul_result;
    assign rsp_flags  = mul_flags;
    assign busy       = (tag_count != '0);
    assign err_orphan = err_orphan_q;

    always_comb begin
        rr_ptr_d     = issue ? ID_W'(wrap_inc(32'(grant), NUM_REQ)) : rr_ptr_q;
        lock_d       = mul_start && !mul_ready;
        lock_id_d    = lock_d ? grant : lock_id_q;
        err_orphan_d = err_orphan_q || (mul_valid && tag_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    fp_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (issue),
        .push_dat (grant),
        .pop      (pop),
        .full     (tag_full),
        .empty    (tag_empty),
        .head     (tag_head),
        .count    (tag_count)
    );

    logic unused_full;
    assign unused_full = tag_full;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed scenarios plus random traffic against a queue-based model.
// The bench plays the multiplier, driving mul_ready/mul_valid/mul_result itself.
module tb_fp_mul_arbiter;
    import fp_mul_arbiter_pkg::*;

    localparam int N = 4;
    localparam int D = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_mode_fp, rsp_valid, rsp_ready;
    logic [N*32-1:0] req_op_a, req_op_b;
    logic            mul_start, mul_ready, mul_mode_fp, mul_valid, mul_ready_in, busy, err_orphan;
    logic [31:0]     mul_op_a, mul_op_b, mul_result, rsp_result;
    logic [4:0]      mul_flags, rsp_flags;

    always #5 clk = ~clk;

    fp_mul_arbiter #(.NUM_REQ(N), .TAG_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op_a     (req_op_a),
        .req_op_b     (req_op_b),
        .req_mode_fp  (req_mode_fp),
        .mul_start    (mul_start),
        .mul_ready    (mul_ready),
        .mul_op_a     (mul_op_a),
        .mul_op_b     (mul_op_b),
        .mul_mode_fp  (mul_mode_fp),
        .mul_valid    (mul_valid),
        .mul_ready_in (mul_ready_in),
        .mul_result   (mul_result),
        .mul_flags    (mul_flags),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .busy         (busy),
        .err_orphan   (err_orphan)
    );

    int n_vec;
    int n_err;

    // Reference model: outstanding requester ids in issue order, rotation pointer, stalled grant.
    int m_q[$];
    int m_rr;
    int m_lock;
    bit m_orphan;
    int gcnt[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rr     = 0;
        m_lock   = -1;
        m_orphan = 1'b0;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_op_a[32*i +: 32] = $urandom;
            req_op_b[32*i +: 32] = $urandom;
        end
        req_mode_fp = 4'($urandom);
        mul_result  = $urandom;
        mul_flags   = 5'($urandom);
    endtask

    task automatic set_idle();
        req_valid = '0;
        mul_valid = 1'b0;
        mul_ready = 1'b1;
        rsp_ready = '1;
    endtask

    // Called at the negedge: compare outputs with the model, then advance both across the posedge.
    task automatic step();
        int grant;
        bit pop, start, issue;
        logic [N-1:0] er, ev;
        bit mri;
        grant = -1;
        if (m_lock >= 0 && req_valid[m_lock]) begin
            grant = m_lock;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (grant < 0 && req_valid[(m_rr + k) % N]) grant = (m_rr + k) % N;
            end
        end
        pop   = mul_valid && (m_q.size() > 0) && rsp_ready[m_q[0]];
        start = (grant >= 0) && ((m_q.size() < D) || pop);
        issue = start && mul_ready;
        er = '0;
        if (issue) er[grant] = 1'b1;
        ev = '0;
        if (mul_valid && m_q.size() > 0) ev[m_q[0]] = 1'b1;
        mri = (m_q.size() == 0) ? 1'b1 : rsp_ready[m_q[0]];

        check("mul_start", 32'(mul_start), 32'(start));
        check("req_ready", 32'(req_ready), 32'(er));
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        check("mul_ready_in", 32'(mul_ready_in), 32'(mri));
        check("busy", 32'(busy), 32'(m_q.size() != 0));
        check("err_orphan", 32'(err_orphan), 32'(m_orphan));
        check("rsp_result", rsp_result, mul_result);
        check("rsp_flags", 32'(rsp_flags), 32'(mul_flags));
        if (start) begin
            check("mul_op_a", mul_op_a, req_op_a[32*grant +: 32]);
            check("mul_op_b", mul_op_b, req_op_b[32*grant +: 32]);
            check("mul_mode_fp", 32'(mul_mode_fp), 32'(req_mode_fp[grant]));
        end

        @(posedge clk);
        if (mul_valid && m_q.size() == 0) m_orphan = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (issue) begin
            m_q.push_back(grant);
            m_rr = (grant + 1) % N;
            gcnt[grant]++;
        end
        m_lock = (start && !mul_ready) ? grant : -1;
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        step();
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        mul_ready = 1'b1;
        for (int i = 0; i < 40 && m_q.size() > 0; i++) begin
            mul_valid = 1'b1;
            cyc();
        end
        mul_valid = 1'b0;
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd0);
        step();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        mul_valid = 1'b1;
        mul_ready = 1'b1;
        rsp_ready = '1;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mul_ready_in", 32'(mul_ready_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_orphan", 32'(err_orphan), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        set_idle();
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        model_reset();
        rand_ops();
        @(posedge clk);
        #1;
        do_reset();

        // Single op from requester 2: 1.5 * 2.0 = 3.0, three-cycle multiplier.
        req_op_a[64 +: 32] = 32'h3FC00000;
        req_op_b[64 +: 32] = 32'h40000000;
        req_mode_fp[2]     = 1'b0;
        req_valid          = 4'b0100;
        @(negedge clk);
        check("single_issue", 32'(req_ready), 32'h4);
        check("single_op_a", mul_op_a, 32'h3FC00000);
        step();
        req_valid = '0;
        cyc();
        cyc();
        mul_valid  = 1'b1;
        mul_result = 32'h40400000;
        mul_flags  = '0;
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 32'h4);
        check("single_result", rsp_result, 32'h40400000);
        check("single_flags", 32'(rsp_flags), 32'd0);
        step();
        mul_valid = 1'b0;
        cyc();

        // Backpressure lock: req 1 stalls 3 cycles, req 0 joins; req 1 must still go first.
        req_op_a[32 +: 32] = 32'h11111111;
        req_op_a[0 +: 32]  = 32'h00000007;
        mul_ready = 1'b0;
        req_valid = 4'b0010;
        cyc();
        req_valid = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lock_op_a", mul_op_a, 32'h11111111);
            check("lock_no_ready", 32'(req_ready), 32'd0);
            step();
        end
        mul_ready = 1'b1;
        @(negedge clk);
        check("lock_issue_1", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0001;
        @(negedge clk);
        check("lock_issue_0", 32'(req_ready), 32'h1);
        step();
        drain();

        // Full: TAG_DEPTH issues with responses blocked.
        rsp_ready = '0;
        req_valid = '1;
        for (int i = 0; i < D; i++) cyc();
        @(negedge clk);
        check("full_no_start", 32'(mul_start), 32'd0);
        step();
        mul_valid = 1'b1;
        rsp_ready = '1;
        @(negedge clk);
        check("full_pushpop_start", 32'(mul_start), 32'd1);
        step();
        mul_valid = 1'b0;
        rsp_ready = '0;
        @(negedge clk);
        check("full_still_full", 32'(mul_start), 32'd0);
        step();
        drain();

        // Ordering: req 3 then req 0 back to back.
        req_valid = 4'b1000;
        cyc();
        req_valid = 4'b0001;
        cyc();
        req_valid = '0;
        mul_valid = 1'b1;
        @(negedge clk);
        check("order_first", 32'(rsp_valid), 32'h8);
        step();
        @(negedge clk);
        check("order_second", 32'(rsp_valid), 32'h1);
        step();
        mul_valid = 1'b0;
        cyc();

        // Fairness: all requesters held valid for 16 issues.
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        req_valid = '1;
        for (int i = 0; i < 16; i++) begin
            mul_valid = (m_q.size() > 0);
            cyc();
        end
        for (int i = 0; i < N; i++) check($sformatf("fair_cnt%0d", i), 32'(gcnt[i]), 32'd4);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req_valid = 4'($urandom);
            mul_ready = ($urandom_range(0, 3) != 0);
            rsp_ready = 4'($urandom);
            mul_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            cyc();
        end
        drain();

        // Orphan result, then reset with work outstanding.
        set_idle();
        mul_valid = 1'b1;
        @(negedge clk);
        check("orphan_mri", 32'(mul_ready_in), 32'd1);
        check("orphan_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        mul_valid = 1'b0;
        @(negedge clk);
        check("orphan_flag", 32'(err_orphan), 32'd1);
        step();
        rsp_ready = '0;
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) cyc();
        req_valid = '0;
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        step();
        do_reset();
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_orphan", 32'(err_orphan), 32'd0);
        step();
        req_valid = 4'b0010;
        @(negedge clk);
        check("post_reset_rr", 32'(req_ready), 32'h2);
        step();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, 4: number of requesters (2..8).
REQ-002 SHALL have parameter TAG_DEPTH, 8: maximum outstanding operations (power of 2).
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  out  NUM_REQ  per-requester accept.
REQ-007 SHALL have port req_op_a / req_op_b  in  NUM_REQ*32 each  operands, requester i at bits [32i+31:32i].
REQ-008 SHALL have port req_mode_fp  in  NUM_REQ  per-requester precision (1 = half, 0 = single).
REQ-009 SHALL have port mul_start / mul_ready  out / in  1 / 1  issue handshake to the multiplier (its start / ready_out).
REQ-010 SHALL have port mul_op_a, mul_op_b, mul_mode_fp  out  32, 32, 1  operands of the granted requester.
REQ-011 SHALL have port mul_valid / mul_ready_in  in / out  1 / 1  result handshake from the multiplier (its valid_out / ready_in).
REQ-012 SHALL have port mul_result, mul_flags  in  32, 5  multiplier result.
REQ-013 SHALL have port rsp_valid / rsp_ready  out / in  NUM_REQ each  per-requester result handshake.
REQ-014 SHALL have port rsp_result, rsp_flags  out  32, 5  shared result bus, a direct copy of mul_result/mul_flags.
REQ-015 SHALL have port busy  out  1  high when outstanding count is nonzero.
REQ-016 SHALL have port err_orphan  out  1  sticky flag: result received with no outstanding tag.

Function
REQ-017 Grant SHALL be round-robin: the first requester with req_valid at or after pointer rr_ptr, with wrap-around.
REQ-018 mul_start SHALL be high when any req_valid is high and a tag slot is free, where a slot is free if count < TAG_DEPTH or a response pops in the same cycle.
REQ-019 Issue SHALL occur when mul_start && mul_ready; on issue, req_ready[grant] = 1 in that cycle, all other req_ready = 0, and the grant id is pushed into the tag FIFO.
REQ-020 Once mul_start is high and mul_ready is low, the grant SHALL be locked (lock register + locked id) until issue; mul_op_* SHALL stay stable; a locked requester that drops req_valid SHALL release the lock.
REQ-021 On issue, rr_ptr SHALL become (grant+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-022 Responses SHALL return in issue order: rsp_valid[head] = mul_valid with FIFO non-empty; all other rsp_valid = 0.
REQ-023 mul_ready_in SHALL equal rsp_ready[head] when the FIFO is non-empty.
REQ-024 Pop SHALL occur when mul_valid && mul_ready_in.
REQ-025 count SHALL update by +1 on push only, -1 on pop only, and hold on both or neither; count is never observable above TAG_DEPTH.
REQ-026 On mul_valid with an empty FIFO, mul_ready_in SHALL be 1 (drain), all rsp_valid = 0, and err_orphan SHALL be set until reset.
REQ-027 Arbitration SHALL add zero latency: issue is combinational in the cycle the request is presented; end-to-end latency equals the multiplier latency.

Reset
REQ-028 On rst_n low: rr_ptr = 0, count = 0, FIFO pointers = 0, lock = 0, err_orphan = 0.
REQ-029 Under reset, req_ready, mul_start, rsp_valid, mul_ready_in and busy SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all outstanding tags; the multiplier shares rst_n, so no stale results follow.

Structure
REQ-031 NUM_REQ default, TAG_DEPTH default and the flag-width constant (5) SHALL live in the shared fp package.
REQ-032 The tag FIFO SHALL be one sub-module, fp_tag_fifo (synchronous, push/pop/full/empty/head, simultaneous push+pop allowed when full).

Verification
REQ-033 Single op: req 2 sends 0x3FC00000 * 0x40000000 single -> after multiplier latency rsp_valid[2] = 1, rsp_result = 0x40400000, flags 0.
REQ-034 Fairness: all 4 req_valid held, mul_ready = 1 -> grants 0, 1, 2, 3, 0, ...; no requester starved over 16 issues.
REQ-035 Backpressure lock: mul_ready low 3 cycles while req 1 granted, req 0 raises valid -> operands stay req 1's, req 1 issues first.
REQ-036 Full: TAG_DEPTH issues with rsp_ready = 0 -> mul_start = 0; one rsp_ready pulse -> push+pop same cycle, count stays 8.
REQ-037 Ordering: req 3 then req 0 issue back-to-back -> responses arrive on rsp_valid[3] then rsp_valid[0].
REQ-038 Orphan/reset: force mul_valid with count 0 -> err_orphan = 1, mul_ready_in = 1; assert rst_n with 3 outstanding -> count 0, busy 0, err_orphan 0.
